// File: rtl/cv32e40p_pkg.sv
// Shared core constants: register-file address layout and APU result width.
// The write-back buffer entry width is derived here so storage and muxing agree.
package cv32e40p_pkg;

    localparam int REGADDR_WIDTH    = 6;
    // Bit 5 of a register address selects the FP file (f[4:0]) over the GPR file (x[4:0]).
    localparam int REGADDR_FP_BIT   = 5;
    localparam int APU_RESULT_WIDTH = 32;

    function automatic int apu_wb_entry_width(input int flag_width);
        return flag_width + REGADDR_WIDTH + APU_RESULT_WIDTH;
    endfunction

endpackage

// File: rtl/cv32e40p_fifo.sv
// Small first-word-fall-through FIFO: head entry is visible on data_o without a read cycle.
// The caller must not push into a full FIFO unless it pops in the same cycle.
module cv32e40p_fifo #(
    parameter int DEPTH      = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [DATA_WIDTH-1:0]    data_i,
    output logic [DATA_WIDTH-1:0]    data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W:0]        r_count;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // DEPTH is a power of two, so pointer overflow is the modulo-DEPTH wrap.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push_i) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (pop_i) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    assign data_o  = r_mem[r_rd_ptr];
    assign count_o = r_count;

endmodule

// File: rtl/cv32e40p_apu_wb_buffer.sv
// Buffers APU results that lose register-file write-port arbitration, with a
// zero-latency bypass when nothing is queued. Results leave in arrival order.
module cv32e40p_apu_wb_buffer
    import cv32e40p_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int FLAG_WIDTH = 5
) (
    input  logic                        clk_i,
    input  logic                        rst_n,
    input  logic                        apu_rvalid_i,
    input  logic [REGADDR_WIDTH-1:0]    apu_waddr_i,
    input  logic [APU_RESULT_WIDTH-1:0] apu_result_i,
    input  logic [FLAG_WIDTH-1:0]       apu_flags_i,
    input  logic                        wb_block_i,
    output logic                        apu_valid_o,
    output logic [REGADDR_WIDTH-1:0]    apu_waddr_o,
    output logic [APU_RESULT_WIDTH-1:0] apu_result_o,
    output logic [FLAG_WIDTH-1:0]       apu_flags_o,
    output logic                        apu_stall_o,
    output logic                        empty_o,
    output logic                        overflow_o
);

    localparam int ENTRY_W = apu_wb_entry_width(FLAG_WIDTH);
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    logic [ENTRY_W-1:0]          w_push_data;
    logic [ENTRY_W-1:0]          w_head_data;
    logic [CNT_W-1:0]            w_count;
    logic [FLAG_WIDTH-1:0]       w_head_flags;
    logic [REGADDR_WIDTH-1:0]    w_head_waddr;
    logic [APU_RESULT_WIDTH-1:0] w_head_result;
    logic                        w_buf_empty;
    logic                        w_full;
    logic                        w_pop;
    logic                        w_push_req;
    logic                        w_drop;
    logic                        w_push;
    logic                        r_overflow;

    assign w_buf_empty = (w_count == '0);
    assign w_full      = (w_count == CNT_W'(DEPTH));

    // The head always drains first; an arriving result only bypasses an empty, unblocked buffer.
    assign w_pop       = ~w_buf_empty & ~wb_block_i;
    assign w_push_req  = apu_rvalid_i & (~w_buf_empty | wb_block_i);
    assign w_drop      = w_push_req & w_full & ~w_pop;
    assign w_push      = w_push_req & ~w_drop;

    assign w_push_data = {apu_flags_i, apu_waddr_i, apu_result_i};
    assign {w_head_flags, w_head_waddr, w_head_result} = w_head_data;

    cv32e40p_fifo #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .data_i  (w_push_data),
        .data_o  (w_head_data),
        .count_o (w_count)
    );

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign apu_valid_o  = (~w_buf_empty | apu_rvalid_i) & ~wb_block_i;
    assign apu_waddr_o  = w_buf_empty ? apu_waddr_i  : w_head_waddr;
    assign apu_result_o = w_buf_empty ? apu_result_i : w_head_result;
    assign apu_flags_o  = w_buf_empty ? apu_flags_i  : w_head_flags;

    // Status decodes only the occupancy register, so no input reaches these combinationally.
    assign empty_o     = w_buf_empty;
    assign apu_stall_o = (w_count >= CNT_W'(DEPTH - 1));
    assign overflow_o  = r_overflow;

endmodule

// File: tb/tb_cv32e40p_apu_wb_buffer.sv
// Bench for the APU write-back buffer: DEPTH=2 and DEPTH=4 instances share one
// stimulus stream and are each compared every cycle against a queue model.
module tb_cv32e40p_apu_wb_buffer;

    typedef struct packed {
        logic [5:0]  waddr;
        logic [31:0] result;
        logic [4:0]  flags;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        apu_rvalid;
    logic [5:0]  apu_waddr;
    logic [31:0] apu_result;
    logic [4:0]  apu_flags;
    logic        wb_block;

    logic [1:0]        v_o;
    logic [1:0][5:0]   waddr_o;
    logic [1:0][31:0]  res_o;
    logic [1:0][4:0]   flg_o;
    logic [1:0]        stall_o;
    logic [1:0]        empty_o;
    logic [1:0]        ovf_o;

    ent_t mq [2][$];
    logic [1:0] movf;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cv32e40p_apu_wb_buffer #(.DEPTH(2), .FLAG_WIDTH(5)) u_dut2 (
        .clk_i(clk), .rst_n(rst_n), .apu_rvalid_i(apu_rvalid), .apu_waddr_i(apu_waddr),
        .apu_result_i(apu_result), .apu_flags_i(apu_flags), .wb_block_i(wb_block),
        .apu_valid_o(v_o[0]), .apu_waddr_o(waddr_o[0]), .apu_result_o(res_o[0]),
        .apu_flags_o(flg_o[0]), .apu_stall_o(stall_o[0]), .empty_o(empty_o[0]),
        .overflow_o(ovf_o[0])
    );

    cv32e40p_apu_wb_buffer #(.DEPTH(4), .FLAG_WIDTH(5)) u_dut4 (
        .clk_i(clk), .rst_n(rst_n), .apu_rvalid_i(apu_rvalid), .apu_waddr_i(apu_waddr),
        .apu_result_i(apu_result), .apu_flags_i(apu_flags), .wb_block_i(wb_block),
        .apu_valid_o(v_o[1]), .apu_waddr_o(waddr_o[1]), .apu_result_o(res_o[1]),
        .apu_flags_o(flg_o[1]), .apu_stall_o(stall_o[1]), .empty_o(empty_o[1]),
        .overflow_o(ovf_o[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outputs: head of the pending queue if any, else the live input.
    task automatic check_outputs();
        for (int m = 0; m < 2; m++) begin
            int   d;
            ent_t e;
            logic ev;
            d = (m == 0) ? 2 : 4;
            if (mq[m].size() > 0) begin
                e  = mq[m][0];
                ev = ~wb_block;
            end else begin
                e  = '{waddr: apu_waddr, result: apu_result, flags: apu_flags};
                ev = apu_rvalid & ~wb_block;
            end
            chk($sformatf("d%0d_valid", d),  64'(v_o[m]),     64'(ev));
            chk($sformatf("d%0d_waddr", d),  64'(waddr_o[m]), 64'(e.waddr));
            chk($sformatf("d%0d_result", d), 64'(res_o[m]),   64'(e.result));
            chk($sformatf("d%0d_flags", d),  64'(flg_o[m]),   64'(e.flags));
            chk($sformatf("d%0d_empty", d),  64'(empty_o[m]), 64'(mq[m].size() == 0));
            chk($sformatf("d%0d_stall", d),  64'(stall_o[m]), 64'(mq[m].size() >= d - 1));
            chk($sformatf("d%0d_ovf", d),    64'(ovf_o[m]),   64'(movf[m]));
        end
    endtask

    // Advance the model across one rising edge with the currently driven inputs.
    task automatic model_clock();
        for (int m = 0; m < 2; m++) begin
            int   d;
            int   sz;
            logic popped;
            logic held;
            d      = (m == 0) ? 2 : 4;
            sz     = mq[m].size();
            popped = (sz > 0) && !wb_block;
            held   = apu_rvalid && ((sz > 0) || wb_block);
            if (popped) void'(mq[m].pop_front());
            if (held) begin
                if (sz == d && !popped) movf[m] = 1'b1;
                else mq[m].push_back('{waddr: apu_waddr, result: apu_result, flags: apu_flags});
            end
        end
    endtask

    task automatic step(input logic rv, input logic [5:0] a, input logic [31:0] r,
                        input logic [4:0] f, input logic b);
        @(negedge clk);
        apu_rvalid = rv;
        apu_waddr  = a;
        apu_result = r;
        apu_flags  = f;
        wb_block   = b;
        #1;
        check_outputs();
        if (rst_n) model_clock();
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) mq[m].delete();
        movf = 2'b00;
    endtask

    initial begin
        rst_n = 1'b0;
        apu_rvalid = 1'b0; apu_waddr = '0; apu_result = '0; apu_flags = '0; wb_block = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_outputs();
        chk("rst_empty", 64'(empty_o[0]), 64'd1);
        chk("rst_stall", 64'(stall_o[0]), 64'd0);
        chk("rst_ovf",   64'(ovf_o[0]),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Bypass straight through an empty buffer
        step(1'b1, 6'h21, 32'hDEADBEEF, 5'h03, 1'b0);
        chk("byp_valid", 64'(v_o[0]), 64'd1);
        chk("byp_waddr", 64'(waddr_o[0]), 64'h21);
        chk("byp_result", 64'(res_o[0]), 64'hDEADBEEF);
        chk("byp_empty", 64'(empty_o[0]), 64'd1);
        step(1'b0, 6'h00, 32'h0, 5'h0, 1'b0);
        chk("byp_empty_after", 64'(empty_o[0]), 64'd1);

        // Blocked port: A and B queue, then drain in order
        step(1'b1, 6'h05, 32'hAAAA0001, 5'h01, 1'b1);
        chk("blk_a_valid", 64'(v_o[0]), 64'd0);
        step(1'b1, 6'h26, 32'hBBBB0002, 5'h02, 1'b1);
        chk("blk_b_valid", 64'(v_o[0]), 64'd0);
        chk("blk_b_empty", 64'(empty_o[0]), 64'd0);
        step(1'b0, 6'h00, 32'h0, 5'h0, 1'b1);
        chk("blk_stall", 64'(stall_o[0]), 64'd1);
        chk("blk_empty", 64'(empty_o[0]), 64'd0);
        step(1'b0, 6'h00, 32'h0, 5'h0, 1'b0);
        chk("rel_a_valid", 64'(v_o[0]), 64'd1);
        chk("rel_a_result", 64'(res_o[0]), 64'hAAAA0001);
        step(1'b0, 6'h00, 32'h0, 5'h0, 1'b0);
        chk("rel_b_valid", 64'(v_o[0]), 64'd1);
        chk("rel_b_result", 64'(res_o[0]), 64'hBBBB0002);
        step(1'b0, 6'h00, 32'h0, 5'h0, 1'b0);
        chk("rel_done_empty", 64'(empty_o[0]), 64'd1);

        // Overflow: three results into a blocked DEPTH=2 buffer
        step(1'b1, 6'h01, 32'h11111111, 5'h01, 1'b1);
        step(1'b1, 6'h02, 32'h22222222, 5'h02, 1'b1);
        step(1'b1, 6'h03, 32'h33333333, 5'h03, 1'b1);
        step(1'b0, 6'h00, 32'h0, 5'h0, 1'b1);
        chk("ovf_set", 64'(ovf_o[0]), 64'd1);
        step(1'b0, 6'h00, 32'h0, 5'h0, 1'b0);
        chk("ovf_w1", 64'(res_o[0]), 64'h11111111);
        step(1'b0, 6'h00, 32'h0, 5'h0, 1'b0);
        chk("ovf_w2", 64'(res_o[0]), 64'h22222222);
        step(1'b0, 6'h00, 32'h0, 5'h0, 1'b0);
        chk("ovf_no_w3", 64'(v_o[0]), 64'd0);
        chk("ovf_sticky", 64'(ovf_o[0]), 64'd1);

        // Asynchronous reset with two entries pending
        step(1'b1, 6'h07, 32'h77770007, 5'h07, 1'b1);
        step(1'b1, 6'h08, 32'h88880008, 5'h08, 1'b1);
        step(1'b0, 6'h00, 32'h0, 5'h0, 1'b1);
        #2;
        apu_rvalid = 1'b1; apu_waddr = 6'h2A; apu_result = 32'hC0FFEE00; wb_block = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        chk("arst_empty", 64'(empty_o[0]), 64'd1);
        chk("arst_stall", 64'(stall_o[0]), 64'd0);
        chk("arst_ovf",   64'(ovf_o[0]),   64'd0);
        chk("arst_valid", 64'(v_o[0]),     64'd1);
        @(negedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 6'h00, 32'h0, 5'h0, 1'b0);
        chk("arst_no_stale", 64'(v_o[0]), 64'd0);

        // Full buffer with simultaneous push and pop
        step(1'b1, 6'h11, 32'hC1C1C1C1, 5'h01, 1'b1);
        step(1'b1, 6'h12, 32'hC2C2C2C2, 5'h02, 1'b1);
        step(1'b1, 6'h13, 32'hC3C3C3C3, 5'h03, 1'b0);
        chk("pp_head", 64'(res_o[0]), 64'hC1C1C1C1);
        step(1'b0, 6'h00, 32'h0, 5'h0, 1'b1);
        chk("pp_stall", 64'(stall_o[0]), 64'd1);
        chk("pp_no_ovf", 64'(ovf_o[0]), 64'd0);
        step(1'b0, 6'h00, 32'h0, 5'h0, 1'b0);
        chk("pp_c2", 64'(res_o[0]), 64'hC2C2C2C2);
        step(1'b0, 6'h00, 32'h0, 5'h0, 1'b0);
        chk("pp_c3", 64'(res_o[0]), 64'hC3C3C3C3);
        step(1'b0, 6'h00, 32'h0, 5'h0, 1'b0);
        chk("pp_empty", 64'(empty_o[0]), 64'd1);

        // Random stream against the model for both depths
        for (int i = 0; i < 600; i++) begin
            logic rv;
            logic b;
            rv = ($urandom_range(0, 1) == 1);
            b  = ($urandom_range(0, 2) == 0);
            step(rv, 6'($urandom), $urandom, 5'($urandom), b);
            if (b) begin
                chk("rnd_blk_d2", 64'(v_o[0]), 64'd0);
                chk("rnd_blk_d4", 64'(v_o[1]), 64'd0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
